ram_bus_arbiter: RTL and testbench
==================================

RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64, meaning max transfers per grant (legal 1..255).
REQ-002 Parameter CPU_SLOT, default 16, meaning clk cycles CPU keeps bus after a release before re-request (legal 1..255).
REQ-003 clk  in  1  CPU clock; all logic on rising edge; nBUSACK and cpu_* are synchronous to it, no synchronizers.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req  in  1  secondary master (loader/debug) wants RAM; level.
REQ-006 req_valid  in  1  transfer request while granted.
REQ-007 req_we  in  1  1=write, 0=read.
REQ-008 req_addr  in  14  RAM address.
REQ-009 req_wdata  in  8  write data.
REQ-010 req_ready  out  1  transfer accepted when req_valid&&req_ready.
REQ-011 req_rdata  out  8  read data, valid only with req_rvalid.
REQ-012 req_rvalid  out  1  one-cycle read-data strobe.
REQ-013 grant  out  1  high exactly while state is GRANT.
REQ-014 nBUSRQ  out  1  to Z80, active-low.
REQ-015 nBUSACK  in  1  from Z80, active-low.
REQ-016 cpu_addr  in  14 / cpu_wdata  in  8 / cpu_we  in  1  CPU-side RAM address, data, decoded write enable.
REQ-017 ram_addr  out  14 / ram_din  out  8 / ram_we  out  1  to synchronous single-port RAM.
REQ-018 ram_dout  in  8  RAM read data, valid one cycle after address is sampled.

Function
REQ-019 States SHALL be IDLE, REQ, GRANT, RELEASE, COOLDOWN; one-hot or binary at implementer's choice.
REQ-020 IDLE: nBUSRQ=1; req=1 -> REQ next cycle; nBUSACK=0 in IDLE ignored.
REQ-021 REQ: nBUSRQ=0; nBUSACK=0 -> GRANT; req=0 (before ack) -> RELEASE.
REQ-022 GRANT: nBUSRQ=0; burst counter cleared on entry, +1 per accepted transfer.
REQ-023 req_ready = (state==GRANT) && (burst<MAX_BURST) && nBUSACK==0.
REQ-024 GRANT exit -> RELEASE when req=0, burst==MAX_BURST, or nBUSACK=1 (lost ack); whichever first, same cycle evaluation.
REQ-025 RELEASE: nBUSRQ=1; waits nBUSACK=1 -> COOLDOWN (immediately if already 1).
REQ-026 COOLDOWN: nBUSRQ=1; counts CPU_SLOT cycles, then IDLE; req ignored until IDLE.
REQ-027 RAM mux: in GRANT ram_addr=req_addr, ram_din=req_wdata, ram_we=req_valid&&req_ready&&req_we; all other states ram_* = cpu_*; combinational.
REQ-028 Read accepted in cycle N -> req_rvalid=1 in cycle N+1 with req_rdata=ram_dout; holds even if state left GRANT at N+1.
REQ-029 req_rvalid registered, one cycle wide; req_rdata undefined-but-stable when req_rvalid=0 (drive ram_dout).
REQ-030 Transfer accepted in last GRANT cycle SHALL complete (write performed, read strobe delivered).
REQ-031 Counters 8-bit, no wrap: burst saturates at MAX_BURST, cooldown counter stops at CPU_SLOT.
REQ-032 No CPU write SHALL reach RAM while grant=1; no requester write outside GRANT.

Reset
REQ-033 reset=1 at any edge -> state IDLE, nBUSRQ=1, grant=0, req_ready=0, req_rvalid=0, counters 0, ram mux to CPU, from the next cycle.
REQ-034 Reset mid-GRANT SHALL abandon outstanding read strobe (req_rvalid=0 next cycle).

Verification
REQ-035 req=1, nBUSACK low 3 cycles after nBUSRQ fall; write 0x5A@0x0123 then read 0x0123 -> ram_we one cycle, req_rvalid next cycle after read with req_rdata=0x5A.
REQ-036 MAX_BURST=4, req held, req_valid constant 1 -> exactly 4 accepts, then nBUSRQ=1, COOLDOWN 16 cycles, re-request on cycle 17 after nBUSACK=1.
REQ-037 req dropped while in REQ (nBUSACK still 1) -> nBUSRQ=1 next cycle, no grant, COOLDOWN entered.
REQ-038 nBUSACK forced high mid-GRANT -> req_ready=0 same cycle, RELEASE next, CPU cpu_we write of 0x11 reaches RAM after grant falls.
REQ-039 reset pulsed the cycle after a read accept in GRANT -> req_rvalid=0, nBUSRQ=1, grant=0 next cycle.
REQ-040 cpu_we=1 during GRANT with req_valid=0 -> ram_we=0 throughout.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares a synchronous single-port RAM between a Z80 CPU and a secondary master
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   req                            secondary master wants the bus (level)
//   req_valid/we/addr/wdata        transfer request, accepted when req_valid && req_ready
//   req_ready, req_rdata, req_rvalid  handshake, read data and one-cycle read strobe
//   grant                          bus currently owned by the secondary master
//   nBUSRQ / nBUSACK               Z80 bus request / acknowledge, active-low
//   cpu_addr/wdata/we              CPU-side RAM access
//   ram_addr/din/we, ram_dout      RAM port, read data one cycle after the address
module ram_bus_arbiter #(
    parameter int MAX_BURST = 64,
    parameter int CPU_SLOT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [13:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic [7:0]  req_rdata,
    output logic        req_rvalid,
    output logic        grant,
    output logic        nBUSRQ,
    input  logic        nBUSACK,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [13:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout
);
    typedef enum logic [2:0] {IDLE, REQ, GRANT, RELEASE, COOLDOWN} stateType;

    localparam logic [7:0] burstMax = 8'(MAX_BURST);
    localparam logic [7:0] slotLen  = 8'(CPU_SLOT);

    stateType   state, stateNext;
    logic [7:0] burstCnt, slotCnt;
    logic       accept;

    // Counters are held at zero outside their state, so entry always starts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burstCnt   <= '0;
            slotCnt    <= '0;
            req_rvalid <= 1'b0;
        end else begin
            state      <= stateNext;
            burstCnt   <= (state != GRANT) ? '0 : burstCnt + 8'(accept && burstCnt < burstMax);
            slotCnt    <= (state != COOLDOWN) ? '0 : slotCnt + 8'(slotCnt < slotLen);
            req_rvalid <= accept && !req_we;
        end
    end

    always_comb begin
        stateNext = state;
        grant     = state == GRANT;
        nBUSRQ    = !(state == REQ || state == GRANT);
        req_ready = grant && burstCnt < burstMax && !nBUSACK;
        accept    = req_valid && req_ready;
        case (state)
            IDLE:     if (req) stateNext = REQ;
            REQ:      if (!nBUSACK) stateNext = GRANT;
                      else if (!req) stateNext = RELEASE;
            // A full burst is only seen the cycle after the last accept, so that cycle idles with ready low
            GRANT:    if (!req || burstCnt == burstMax || nBUSACK) stateNext = RELEASE;
            RELEASE:  if (nBUSACK) stateNext = COOLDOWN;
            COOLDOWN: if (slotCnt >= slotLen - 8'd1) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
        ram_addr = grant ? req_addr : cpu_addr;
        ram_din  = grant ? req_wdata : cpu_wdata;
        ram_we   = grant ? accept && req_we : cpu_we;
    end

    assign req_rdata = ram_dout;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: table, directed and randomized checks of ram_bus_arbiter against a phase model
module tb_ram_bus_arbiter;
    localparam int MAXB = 4;
    localparam int SLOT = 16;
    localparam int P_IDLE = 0, P_REQ = 1, P_GRANT = 2, P_REL = 3, P_COOL = 4;

    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic        nBUSACK = 1'b1, cpu_we = 1'b0;
    logic [13:0] req_addr = '0, cpu_addr = '0, ram_addr;
    logic [7:0]  req_wdata = '0, cpu_wdata = '0, ram_din, ram_dout, req_rdata;
    logic        req_ready, req_rvalid, grant, nBUSRQ, ram_we;

    logic [7:0]  ramMem [16384];
    logic [7:0]  refMem [16384];
    int          phase = P_IDLE, done = 0, left = 0, total = 0, bad = 0;
    logic        expRv = 1'b0;
    logic [7:0]  expRd = '0;

    typedef struct {
        logic        rq, ack, vld, we;
        logic [13:0] addr;
        logic [7:0]  wd;
        logic        gnt, busrq, rdy, rwe, rv;
        logic [7:0]  rd;
    } vecType;
    vecType tbl [11];

    ram_bus_arbiter #(.MAX_BURST(MAXB), .CPU_SLOT(SLOT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .req_rdata(req_rdata), .req_rvalid(req_rvalid), .grant(grant), .nBUSRQ(nBUSRQ),
        .nBUSACK(nBUSACK), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ramMem[ram_addr] <= ram_din;
        ram_dout <= ramMem[ram_addr];
    end

    function automatic logic eGrant(); return phase == P_GRANT; endfunction
    function automatic logic eReady(); return eGrant() && done < MAXB && !nBUSACK; endfunction
    function automatic logic eAcc(); return req_valid && eReady(); endfunction
    function automatic logic eWe(); return eGrant() ? eAcc() && req_we : cpu_we; endfunction
    function automatic logic [13:0] eAddr(); return eGrant() ? req_addr : cpu_addr; endfunction
    function automatic logic [7:0] eDin(); return eGrant() ? req_wdata : cpu_wdata; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #4;
        chk("grant", 32'(grant), 32'(eGrant()));
        chk("nBUSRQ", 32'(nBUSRQ), 32'(!(phase == P_REQ || phase == P_GRANT)));
        chk("req_ready", 32'(req_ready), 32'(eReady()));
        chk("ram_we", 32'(ram_we), 32'(eWe()));
        chk("ram_addr", 32'(ram_addr), 32'(eAddr()));
        chk("ram_din", 32'(ram_din), 32'(eDin()));
        chk("req_rvalid", 32'(req_rvalid), 32'(expRv));
        if (expRv) chk("req_rdata", 32'(req_rdata), 32'(expRd));
    endtask

    task automatic modelStep();
        logic acc;
        acc = eAcc();
        if (eWe()) refMem[eAddr()] = eDin();
        if (reset) begin
            phase = P_IDLE;
            done  = 0;
            left  = 0;
            expRv = 1'b0;
            return;
        end
        expRv = acc && !req_we;
        expRd = refMem[req_addr];
        case (phase)
            P_IDLE:  if (req) phase = P_REQ;
            P_REQ:   if (!nBUSACK) begin phase = P_GRANT; done = 0; end
                     else if (!req) phase = P_REL;
            P_GRANT: begin
                if (!req || done == MAXB || nBUSACK) phase = P_REL;
                if (acc) done++;
            end
            P_REL:   if (nBUSACK) begin phase = P_COOL; left = SLOT; end
            default: begin left--; if (left == 0) phase = P_IDLE; end
        endcase
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idleCycles(input int n);
        req = 1'b0; req_valid = 1'b0; nBUSACK = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < n; i++) begin settle(); advance(); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int acc, n;
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 14'h0,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 14'h0,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'h0,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 14'h123, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 14'h123, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'h123, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0,   8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h0,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        advance();
        advance();
        reset = 1'b0;

        // Fill the low addresses through the CPU path so every later read has a known value
        for (int i = 0; i < 16; i++) begin
            cpu_we = 1'b1; cpu_addr = 14'(i); cpu_wdata = 8'(i * 37 + 5);
            settle(); advance();
        end
        cpu_we = 1'b0;

        // Request, late acknowledge, write 0x5A then read it back, release
        foreach (tbl[i]) begin
            req = tbl[i].rq; nBUSACK = tbl[i].ack; req_valid = tbl[i].vld; req_we = tbl[i].we;
            req_addr = tbl[i].addr; req_wdata = tbl[i].wd;
            settle();
            chk("t_grant", 32'(grant), 32'(tbl[i].gnt));
            chk("t_nBUSRQ", 32'(nBUSRQ), 32'(tbl[i].busrq));
            chk("t_ready", 32'(req_ready), 32'(tbl[i].rdy));
            chk("t_ram_we", 32'(ram_we), 32'(tbl[i].rwe));
            chk("t_rvalid", 32'(req_rvalid), 32'(tbl[i].rv));
            if (tbl[i].rv) chk("t_rdata", 32'(req_rdata), 32'(tbl[i].rd));
            advance();
        end
        idleCycles(20);

        // Request withdrawn before acknowledge: release, then a full cooldown ignoring req
        req = 1'b1; nBUSACK = 1'b1;
        settle(); advance();
        req = 1'b0;
        settle();
        chk("drop_busrq_low", 32'(nBUSRQ), 32'd0);
        advance();
        settle();
        chk("drop_busrq_high", 32'(nBUSRQ), 32'd1);
        chk("drop_no_grant", 32'(grant), 32'd0);
        advance();
        req = 1'b1;
        n = 0;
        while (nBUSRQ && n < 40) begin settle(); advance(); n++; end
        chk("drop_cooldown_len", 32'(n), 32'(SLOT + 1));

        // Burst limit with req_valid held high, then cooldown length before re-request
        nBUSACK = 1'b0; req_valid = 1'b1; req_we = 1'b1;
        settle(); advance();
        acc = 0;
        n = 0;
        while (grant && n < 20) begin
            req_addr = 14'($urandom_range(0, 15)); req_wdata = 8'($urandom);
            settle();
            if (req_valid && req_ready) acc++;
            advance();
            n++;
        end
        chk("burst_accepts", 32'(acc), 32'(MAXB));
        chk("burst_release", 32'(nBUSRQ), 32'd1);
        nBUSACK = 1'b1; req_valid = 1'b0;
        n = 0;
        while (nBUSRQ && n < 40) begin settle(); advance(); n++; end
        chk("slot_to_rerequest", 32'(n), 32'(SLOT + 2));

        // CPU writes blocked during grant; lost acknowledge drops ready at once and hands RAM back
        nBUSACK = 1'b0;
        settle(); advance();
        cpu_we = 1'b1; cpu_addr = 14'd5; cpu_wdata = 8'h77; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("cpu_we_in_grant", 32'(ram_we), 32'd0);
            advance();
        end
        nBUSACK = 1'b1; req_valid = 1'b1; req_we = 1'b1; cpu_wdata = 8'h11;
        settle();
        chk("lost_ack_ready", 32'(req_ready), 32'd0);
        chk("lost_ack_ram_we", 32'(ram_we), 32'd0);
        advance();
        settle();
        chk("lost_ack_grant", 32'(grant), 32'd0);
        chk("cpu_write_we", 32'(ram_we), 32'd1);
        chk("cpu_write_addr", 32'(ram_addr), 32'd5);
        chk("cpu_write_din", 32'(ram_din), 32'h11);
        advance();
        idleCycles(20);

        // Reset the cycle after a read accept
        req = 1'b1; nBUSACK = 1'b1;
        n = 0;
        while (nBUSRQ && n < 10) begin settle(); advance(); n++; end
        chk("rst_req_seen", 32'(nBUSRQ), 32'd0);
        nBUSACK = 1'b0;
        settle(); advance();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'd3;
        settle();
        chk("rst_read_ready", 32'(req_ready), 32'd1);
        advance();
        reset = 1'b1; req_valid = 1'b0;
        settle();
        chk("rst_strobe_before", 32'(req_rvalid), 32'd1);
        advance();
        reset = 1'b0; req = 1'b0; nBUSACK = 1'b1;
        settle();
        chk("rst_rvalid", 32'(req_rvalid), 32'd0);
        chk("rst_nBUSRQ", 32'(nBUSRQ), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        advance();

        // Randomized traffic with a loosely behaved Z80 acknowledge
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 15) == 0) req = !req;
            nBUSACK = nBUSRQ ? $urandom_range(0, 7) != 0 : $urandom_range(0, 9) == 0;
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom_range(0, 1));
            req_addr = 14'($urandom_range(0, 15));
            req_wdata = 8'($urandom);
            cpu_we = $urandom_range(0, 3) == 0;
            cpu_addr = 14'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            settle(); advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
